// File: rtl/ahb_si_resp_router_pkg.sv
// Shared AHB slave-interface types and constants for the multilayer interconnect.
package ahb_si_resp_router_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  localparam int SI_PAYLOAD = 33;  // {HRESP, HRDATA}
  localparam int MI_PAYLOAD = 78;

  // Index of the set bit of a one-hot vector; 0 when the vector is zero.
  function automatic logic [4:0] onehot_to_idx(input logic [31:0] oh);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ahb_si_resp_router_arb.sv
// Combinational round-robin pick: searches from ptr+1 (mod CHANNEL_NUM) for the first request.
module ahb_rr_arbiter
  import ahb_si_resp_router_pkg::*;
#(
  parameter int CHANNEL_NUM = 7,
  localparam int PW = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1
) (
  input  logic [CHANNEL_NUM-1:0] req,
  input  logic [PW-1:0]          ptr,
  output logic [CHANNEL_NUM-1:0] gnt,
  output logic [PW-1:0]          gnt_idx,
  output logic                   vld
);

  logic [PW:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = ptr;
    vld     = 1'b0;
    cand    = '0;
    for (int k = 1; k <= CHANNEL_NUM; k++) begin
      // ptr + k never exceeds 2*CHANNEL_NUM-1, so one conditional subtract wraps it.
      cand = {1'b0, ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(CHANNEL_NUM)) cand = cand - (PW+1)'(CHANNEL_NUM);
      if (!vld && req[cand[PW-1:0]]) begin
        vld                = 1'b1;
        gnt[cand[PW-1:0]]  = 1'b1;
        gnt_idx            = cand[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/ahb_si_resp_router.sv
// AHB slave-port grant/data-phase tracking and per-master response fan-out.
module ahb_si_resp_router
  import ahb_si_resp_router_pkg::*;
#(
  parameter int CHANNEL_NUM = 7,
  parameter int PAY_LOAD    = SI_PAYLOAD,
  localparam int PW = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1
) (
  input  logic                                HCLK,
  input  logic                                HRESET,
  input  logic [CHANNEL_NUM-1:0]              hreq,
  input  logic [1:0]                          htrans_in,
  input  logic                                hmastlock_in,
  input  logic                                hreadyout_s,
  input  logic [PAY_LOAD-1:0]                 payload_in,
  output logic [CHANNEL_NUM-1:0]              sel_addr,
  output logic [CHANNEL_NUM-1:0]              sel_data,
  output logic                                hready_s,
  output logic [CHANNEL_NUM-1:0]              addr_ack,
  output logic [CHANNEL_NUM-1:0]              resp_valid,
  output logic [CHANNEL_NUM-1:0][PAY_LOAD-1:0] payload_out
);

  logic [CHANNEL_NUM-1:0] sel_addr_q, sel_addr_d;
  logic [CHANNEL_NUM-1:0] sel_data_q, sel_data_d;
  logic [PW-1:0]          rr_ptr_q, rr_ptr_d;

  logic [CHANNEL_NUM-1:0] arb_gnt;
  logic [PW-1:0]          arb_idx;
  logic                   arb_vld;
  logic                   owner_req;
  logic                   hold;

  ahb_rr_arbiter #(.CHANNEL_NUM(CHANNEL_NUM)) u_arb (
    .req     (hreq),
    .ptr     (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .vld     (arb_vld)
  );

  // Locked sequences and bursts keep the address phase; a SEQ whose owner dropped hreq does not.
  assign owner_req = |(hreq & sel_addr_q);
  assign hold = (|sel_addr_q) &&
                ((hmastlock_in && owner_req) ||
                 (htrans_in == BUSY) ||
                 (htrans_in == SEQ && owner_req));

  always_comb begin
    sel_addr_d = sel_addr_q;
    sel_data_d = sel_data_q;
    rr_ptr_d   = rr_ptr_q;
    if (hreadyout_s) begin
      sel_data_d = htrans_in[1] ? sel_addr_q : '0;
      if (!hold) begin
        sel_addr_d = arb_gnt;
        if (arb_vld) rr_ptr_d = arb_idx;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sel_addr_q <= '0;
      sel_data_q <= '0;
      rr_ptr_q   <= PW'(CHANNEL_NUM - 1);
    end else begin
      sel_addr_q <= sel_addr_d;
      sel_data_q <= sel_data_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign sel_addr   = sel_addr_q;
  assign sel_data   = sel_data_q;
  assign hready_s   = hreadyout_s;
  assign addr_ack   = sel_addr_q & {CHANNEL_NUM{hreadyout_s}};
  assign resp_valid = sel_data_q & {CHANNEL_NUM{hreadyout_s}};

  for (genvar i = 0; i < CHANNEL_NUM; i++) begin : g_fanout
    assign payload_out[i] = sel_data_q[i] ? payload_in : '0;
  end

endmodule

// File: tb/tb_ahb_si_resp_router.sv
// Scoreboard bench for ahb_si_resp_router: directed scenarios followed by constrained random traffic.
module tb_ahb_si_resp_router;
  localparam int N = 7;
  localparam int P = 33;

  logic              HCLK = 1'b0;
  logic              HRESET;
  logic [N-1:0]      hreq;
  logic [1:0]        htrans_in;
  logic              hmastlock_in;
  logic              hreadyout_s;
  logic [P-1:0]      payload_in;
  logic [N-1:0]      sel_addr, sel_data, addr_ack, resp_valid;
  logic              hready_s;
  logic [N-1:0][P-1:0] payload_out;

  ahb_si_resp_router #(.CHANNEL_NUM(N), .PAY_LOAD(P)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .hreq(hreq), .htrans_in(htrans_in),
    .hmastlock_in(hmastlock_in), .hreadyout_s(hreadyout_s), .payload_in(payload_in),
    .sel_addr(sel_addr), .sel_data(sel_data), .hready_s(hready_s), .addr_ack(addr_ack),
    .resp_valid(resp_valid), .payload_out(payload_out)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed { logic [N-1:0] a; logic [N-1:0] d; } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  logic [N-1:0] m_addr = '0, m_data = '0;
  int m_ptr = N-1;
  bit m_valid = 0;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Reference next-state of the grant/data-phase registers.
  task automatic model_next(output logic [N-1:0] na, output logic [N-1:0] nd, output int np);
    int o;
    bit hold;
    na = m_addr; nd = m_data; np = m_ptr;
    if (HRESET) begin
      na = '0; nd = '0; np = N-1;
    end else if (hreadyout_s) begin
      nd = htrans_in[1] ? m_addr : '0;
      o = -1;
      for (int i = 0; i < N; i++) if (m_addr[i]) o = i;
      hold = (o >= 0) && ((hmastlock_in && hreq[o]) || htrans_in == 2'b01 ||
                          (htrans_in == 2'b11 && hreq[o]));
      if (!hold) begin
        na = '0;
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (na == '0 && hreq[c]) begin na[c] = 1'b1; np = c; end
        end
      end
    end
  endtask

  task automatic step();
    exp_t e;
    logic [N-1:0] na, nd;
    logic [N-1:0][P-1:0] pexp;
    int np;
    #1;
    if (m_valid) begin
      for (int i = 0; i < N; i++) pexp[i] = m_data[i] ? payload_in : '0;
      chk("resp_valid", resp_valid, m_data & {N{hreadyout_s}});
      chk("addr_ack", addr_ack, m_addr & {N{hreadyout_s}});
      chk("hready_s", hready_s, hreadyout_s);
      chk("payload_out", payload_out, pexp);
    end
    model_next(na, nd, np);
    e.a = na; e.d = nd;
    sb.push_back(e);
    @(posedge HCLK); #1;
    e = sb.pop_front();
    chk("sel_addr", sel_addr, e.a);
    chk("sel_data", sel_data, e.d);
    m_addr = na; m_data = nd; m_ptr = np; m_valid = 1;
  endtask

  // Invariants and the master-side protocol rule that a SEQ owner keeps requesting.
  a_oh_addr: assert property (@(posedge HCLK) disable iff (HRESET) $onehot0(sel_addr))
    else $error("sel_addr not onehot0");
  a_oh_data: assert property (@(posedge HCLK) disable iff (HRESET) $onehot0(sel_data))
    else $error("sel_data not onehot0");
  a_seq_req: assert property (@(posedge HCLK) disable iff (HRESET)
    (hreadyout_s && htrans_in == 2'b11 && |sel_addr) |-> |(hreq & sel_addr))
    else $error("SEQ presented while owner hreq low");

  initial begin
    HRESET = 1; hreq = '0; htrans_in = 2'b00; hmastlock_in = 0; hreadyout_s = 1; payload_in = '0;
    step();
    chk("rst_addr", sel_addr, 7'b0); chk("rst_data", sel_data, 7'b0); chk("rst_resp", resp_valid, 7'b0);
    HRESET = 0;

    // Round robin between masters 0 and 2.
    hreq = 7'b0000101; htrans_in = 2'b10;
    step(); chk("rr_c1", sel_addr, 7'b0000001);
    step(); chk("rr_c2", sel_addr, 7'b0000100); chk("rr_c2_data", sel_data, 7'b0000001);
    step(); chk("rr_c3_data", sel_data, 7'b0000100);

    // INCR4 from master 3 is not broken while others request.
    hreq = 7'b0001000; step(); chk("b_grant", sel_addr, 7'b0001000);
    step(); chk("b_beat0", sel_addr, 7'b0001000);
    hreq = 7'h7F; htrans_in = 2'b11;
    for (int b = 1; b <= 3; b++) begin step(); chk("b_beat", sel_addr, 7'b0001000); end
    htrans_in = 2'b00; step(); chk("b_after", sel_addr, 7'b0010000);

    // Master 1 response with two wait states.
    hreq = 7'b0000010; htrans_in = 2'b10; step(); chk("w_grant", sel_addr, 7'b0000010);
    hreq = '0; step(); chk("w_data", sel_data, 7'b0000010);
    htrans_in = 2'b00; hreadyout_s = 0; payload_in = 33'h0_DEADBEEF;
    for (int w = 0; w < 2; w++) begin
      step(); chk("w_frozen", sel_data, 7'b0000010); chk("w_resp0", resp_valid, 7'b0);
    end
    hreadyout_s = 1; #1;
    chk("w_resp1", resp_valid, 7'b0000010); chk("w_pay1", payload_out[1], 33'h0_DEADBEEF);
    chk("w_pay0", payload_out[0], 33'h0);
    step();

    // Two-cycle ERROR response to master 2.
    hreq = 7'b0000100; htrans_in = 2'b00; step(); chk("e_grant", sel_addr, 7'b0000100);
    hreq = '0; htrans_in = 2'b10; step();
    htrans_in = 2'b00; payload_in = 33'h1_00000000; hreadyout_s = 0; #1;
    chk("e_hresp0", payload_out[2][32], 1'b1); chk("e_resp0", resp_valid, 7'b0);
    step();
    hreadyout_s = 1; #1;
    chk("e_hresp1", payload_out[2][32], 1'b1); chk("e_resp1", resp_valid, 7'b0000100);
    step();

    // Locked transfers from master 5.
    hreq = 7'b0100000; step(); chk("l_grant", sel_addr, 7'b0100000);
    hreq = 7'h7F; hmastlock_in = 1; htrans_in = 2'b10;
    for (int l = 0; l < 3; l++) begin step(); chk("l_hold", sel_addr, 7'b0100000); end
    hmastlock_in = 0; step(); chk("l_release", sel_addr, 7'b1000000);

    // Reset during a stalled data phase.
    hreq = 7'b0000001; step(); chk("r_data", sel_data, 7'b1000000);
    hreadyout_s = 0; HRESET = 1; htrans_in = 2'b00;
    step(); chk("r_addr0", sel_addr, 7'b0); chk("r_data0", sel_data, 7'b0);
    #1 chk("r_resp0", resp_valid, 7'b0);
    HRESET = 0; hreadyout_s = 1; hreq = 7'h7F; step(); chk("r_first", sel_addr, 7'b0000001);

    // Constrained random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      HRESET = ($urandom_range(0, 59) == 0);
      hreq = N'($urandom);
      hreadyout_s = ($urandom_range(0, 3) != 0);
      hmastlock_in = ($urandom_range(0, 7) == 0);
      htrans_in = 2'($urandom);
      payload_in = {1'($urandom), $urandom};
      if (m_addr == '0) htrans_in = 2'b00;
      if (htrans_in == 2'b11) hreq = hreq | m_addr;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
